calc_sequencer: RTL and testbench

- Programmable controller that drives the calc accumulator/ALU datapath without manual buttons.
- Holds a small program of (ALU op, 16-bit operand) entries and sequences them on start: optional accumulator clear, then per entry: drive op/operand, pulse apply, wait settle, capture result.
- Sits between a host/bench and the calc inputs. Its outputs map to calc as: alu_op = {btnl, btnc, btnr}, sw_out = sw, apply = btnd, acc_rst = btnu, led_in = led.

---
 rtl/calc_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Programmable controller for the calc accumulator/ALU datapath. It holds a
//   program of (ALU op, 16-bit operand) entries. On start it can clear the
//   accumulator first. For each entry it then drives op/operand, pulses apply,
//   waits SETTLE cycles and captures the calc result.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   prog_we/addr/data   program write port; data = {op[2:0], operand[15:0]}
//   prog_len            number of entries to run, saturated to DEPTH
//   start, clr_first    begin a run (IDLE only); clear accumulator first
//   abort               return to IDLE next cycle, overrides everything
//   led_in              calc result input
//   alu_op, sw_out      op/operand to calc ({btnl,btnc,btnr} and sw)
//   apply, acc_rst      one-cycle pulses to calc (btnd and btnu)
//   busy, done          run in progress / one-cycle completion pulse
//   result, step_cnt    last captured led_in / entries completed this run
//   dbg_state           current FSM state
//
// Handshake: start is a single-cycle request that is taken only when busy is
// low; there is no back-pressure. apply, acc_rst and done are one-cycle pulses.
module calc_sequencer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [18:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          clr_first,
  input  logic          abort,
  input  logic [15:0]   led_in,
  output logic [2:0]    alu_op,
  output logic [15:0]   sw_out,
  output logic          apply,
  output logic          acc_rst,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result,
  output logic [AW:0]   step_cnt,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam int            WW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0] WLOAD   = WW'(SETTLE - 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_L   = (AW + 1)'(1);

  state_t        state, state_d;
  logic [AW-1:0] pc, pc_d;
  logic [AW:0]   len_q, len_d, len_sat;
  logic [WW-1:0] wcnt, wcnt_d;
  logic [AW:0]   step_d;
  logic [15:0]   result_d;
  logic [2:0]    op_d;
  logic [15:0]   sw_d;
  logic          apply_d, acc_rst_d, done_d, busy_d;
  logic          last;

  logic [18:0]   mem [DEPTH];

  assign len_sat   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last      = ({1'b0, pc} == (len_q - ONE_L));
  assign dbg_state = state;

  // Program memory: writable only while idle, never reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Next-state and next-output logic. Every output register is loaded with
  // the value that belongs to the state being entered, so the pulses line
  // up exactly with their states.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    len_d     = len_q;
    wcnt_d    = wcnt;
    step_d    = step_cnt;
    result_d  = result;
    op_d      = alu_op;
    sw_d      = sw_out;
    apply_d   = 1'b0;
    acc_rst_d = 1'b0;
    done_d    = 1'b0;
    busy_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          len_d  = len_sat;
          pc_d   = '0;
          step_d = '0;
          if (clr_first)           state_d = S_CLEAR;
          else if (len_sat != '0)  state_d = S_ISSUE;
          else                     state_d = S_FIN;
        end
      end
      S_CLEAR: begin
        state_d = (len_q != '0) ? S_ISSUE : S_FIN;
      end
      S_ISSUE: begin
        wcnt_d  = WLOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt == '0) state_d = S_CAPTURE;
        else            wcnt_d  = wcnt - 1'b1;
      end
      S_CAPTURE: begin
        result_d = led_in;
        step_d   = step_cnt + ONE_L;
        if (last) begin
          state_d = S_FIN;
        end else begin
          pc_d    = pc + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a start in the same cycle;
    // progress registers keep what they had.
    if (abort) begin
      state_d  = S_IDLE;
      pc_d     = pc;
      len_d    = len_q;
      wcnt_d   = wcnt;
      step_d   = step_cnt;
      result_d = result;
    end

    if (state_d == S_ISSUE) begin
      op_d    = mem[pc_d][18:16];
      sw_d    = mem[pc_d][15:0];
      apply_d = 1'b1;
    end
    acc_rst_d = (state_d == S_CLEAR);
    done_d    = (state_d == S_FIN);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      len_q    <= '0;
      wcnt     <= '0;
      step_cnt <= '0;
      result   <= '0;
      alu_op   <= '0;
      sw_out   <= '0;
      apply    <= 1'b0;
      acc_rst  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      len_q    <= len_d;
      wcnt     <= wcnt_d;
      step_cnt <= step_d;
      result   <= result_d;
      alu_op   <= op_d;
      sw_out   <= sw_d;
      apply    <= apply_d;
      acc_rst  <= acc_rst_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//   Directed bench for calc_sequencer. A behavioural calc accumulator model
//   closes the loop on led_in. Expected results are hand-computed constants.
module tb_calc_sequencer;

  localparam int AW = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [18:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          clr_first;
  logic          abort;
  logic [15:0]   led_in;
  logic [2:0]    alu_op;
  logic [15:0]   sw_out;
  logic          apply;
  logic          acc_rst;
  logic          busy;
  logic          done;
  logic [15:0]   result;
  logic [AW:0]   step_cnt;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  int apply_cnt  = 0;
  int accrst_cnt = 0;
  int done_cnt   = 0;
  int since_apply = -1;
  logic        mon_on = 1'b0;
  logic [2:0]  ap_op;
  logic [15:0] ap_sw;
  logic [15:0] acc;
  logic [15:0] exp_q[$];
  int          cyc;

  logic [2:0]  prog_ops  [9] = '{3'd2, 3'd3, 3'd1, 3'd0, 3'd7, 3'd2, 3'd5, 3'd6, 3'd4};
  logic [15:0] prog_vals [9] = '{16'h354a, 16'h1234, 16'h1001, 16'hf0f0, 16'h1fa2,
                                 16'h6aa2, 16'h0004, 16'h0001, 16'h46ff};
  logic [15:0] exp_res   [9] = '{16'h354a, 16'h2316, 16'h3317, 16'h3010, 16'h2fb2,
                                 16'h9a54, 16'ha540, 16'hd2a0, 16'h0001};

  calc_sequencer #(.DEPTH(16), .AW(AW), .SETTLE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .clr_first (clr_first),
    .abort     (abort),
    .led_in    (led_in),
    .alu_op    (alu_op),
    .sw_out    (sw_out),
    .apply     (apply),
    .acc_rst   (acc_rst),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .step_cnt  (step_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- calc accumulator model ----------------
  function automatic logic [15:0] alu(input logic [15:0] a, input logic [2:0] op,
                                      input logic [15:0] b);
    case (op)
      3'd0: alu = a & b;
      3'd1: alu = a | b;
      3'd2: alu = a + b;
      3'd3: alu = a - b;
      3'd4: alu = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd5: alu = a << b[3:0];
      3'd6: alu = 16'($signed(a) >>> b[3:0]);
      default: alu = a ^ b;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc <= 16'h0;
    else if (acc_rst)  acc <= 16'h0;
    else if (apply)    acc <= alu(acc, alu_op, sw_out);
  end
  assign led_in = acc;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: counts pulses; when enabled, tracks each apply and checks
  // operand stability, the capture slot and the captured result.
  always @(negedge clk) begin
    if (apply === 1'b1)   apply_cnt++;
    if (acc_rst === 1'b1) accrst_cnt++;
    if (done === 1'b1)    done_cnt++;
    if (!mon_on) begin
      since_apply = -1;
    end else begin
      if (since_apply >= 0) since_apply++;
      if (since_apply >= 1 && since_apply <= 3) begin
        check("op_stable", 32'(alu_op), 32'(ap_op));
        check("sw_stable", 32'(sw_out), 32'(ap_sw));
      end
      if (since_apply == 3) check("capture_slot", 32'(dbg_state), 32'(S_CAPTURE));
      if (since_apply == 4) begin
        since_apply = -1;
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL capture_extra observed=%0h expected=none", result);
        end
        if (exp_q.size() != 0) check("capture_result", 32'(result), 32'(exp_q.pop_front()));
      end
      if (apply === 1'b1) begin
        since_apply = 0;
        ap_op = alu_op;
        ap_sw = sw_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; clr_first = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [2:0] op, input logic [15:0] v);
    prog_we = 1'b1; prog_addr = a; prog_data = {op, v};
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_res[i]);
  endtask

  // Called at a negedge; start is taken at the following posedge.
  task automatic start_run(input logic [AW:0] len, input logic clr);
    apply_cnt = 0; accrst_cnt = 0; done_cnt = 0;
    start = 1'b1; prog_len = len; clr_first = clr;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the number of negedges after the start edge until done is seen.
  task automatic wait_done(input int budget, output int c_out);
    c_out = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        c_out = c;
        break;
      end
    end
    if (c_out == 0) check("done_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    check("rst_alu_op",   32'(alu_op),    32'h0);
    check("rst_sw_out",   32'(sw_out),    32'h0);
    check("rst_apply",    32'(apply),     32'h0);
    check("rst_acc_rst",  32'(acc_rst),   32'h0);
    check("rst_busy",     32'(busy),      32'h0);
    check("rst_done",     32'(done),      32'h0);
    check("rst_result",   32'(result),    32'h0);
    check("rst_step_cnt", 32'(step_cnt),  32'h0);
    check("rst_state",    32'(dbg_state), 32'(S_IDLE));

    for (int i = 0; i < 9; i++) write_entry(AW'(i), prog_ops[i], prog_vals[i]);

    // Full program with accumulator clear.
    load_exp(9);
    mon_on = 1'b1;
    start_run(5'd9, 1'b1);
    wait_done(100, cyc);
    check("main_cycles", 32'(cyc), 32'd38);
    repeat (2) @(negedge clk);
    check("main_apply_cnt",  32'(apply_cnt),  32'd9);
    check("main_accrst_cnt", 32'(accrst_cnt), 32'd1);
    check("main_done_cnt",   32'(done_cnt),   32'd1);
    check("main_step_cnt",   32'(step_cnt),   32'd9);
    check("main_result",     32'(result),     32'h0001);
    check("main_busy",       32'(busy),       32'd0);
    check("main_exp_left",   32'(exp_q.size()), 32'd0);

    // len=0 with clear: CLEAR then FIN.
    start_run(5'd0, 1'b1);
    wait_done(20, cyc);
    check("len0c_cycles", 32'(cyc), 32'd2);
    repeat (2) @(negedge clk);
    check("len0c_accrst_cnt", 32'(accrst_cnt), 32'd1);
    check("len0c_apply_cnt",  32'(apply_cnt),  32'd0);
    check("len0c_done_cnt",   32'(done_cnt),   32'd1);
    check("len0c_step_cnt",   32'(step_cnt),   32'd0);

    // len=0 without clear: done on the cycle after start.
    start_run(5'd0, 1'b0);
    wait_done(20, cyc);
    check("len0_cycles", 32'(cyc), 32'd1);
    repeat (2) @(negedge clk);
    check("len0_accrst_cnt", 32'(accrst_cnt), 32'd0);
    check("len0_apply_cnt",  32'(apply_cnt),  32'd0);

    // Abort in WAIT of entry 3 (entry 3 occupies cycles 10..13).
    mon_on = 1'b0;
    start_run(5'd9, 1'b1);
    repeat (11) @(negedge clk);
    check("abort_in_wait", 32'(dbg_state), 32'(S_WAIT));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_step_cnt", 32'(step_cnt), 32'd2);
    check("abort_result",   32'(result),   32'h2316);
    repeat (4) @(negedge clk);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_apply",    32'(apply),    32'd0);

    // Restart after abort begins at entry 0.
    load_exp(2);
    mon_on = 1'b1;
    start_run(5'd2, 1'b1);
    wait_done(50, cyc);
    check("restart_cycles", 32'(cyc), 32'd10);
    repeat (2) @(negedge clk);
    check("restart_step_cnt", 32'(step_cnt), 32'd2);
    check("restart_result",   32'(result),   32'h2316);

    // Program write and second start while busy are both dropped.
    load_exp(9);
    start_run(5'd9, 1'b1);
    repeat (3) @(negedge clk);
    prog_we = 1'b1; prog_addr = '0; prog_data = 19'h2_0000;
    start = 1'b1; prog_len = 5'd1; clr_first = 1'b0;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done(100, cyc);
    check("busy_cycles", 32'(cyc), 32'd34);
    repeat (2) @(negedge clk);
    check("busy_step_cnt", 32'(step_cnt), 32'd9);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);
    load_exp(1);
    start_run(5'd1, 1'b1);
    wait_done(50, cyc);
    check("rerun_cycles", 32'(cyc), 32'd6);
    repeat (2) @(negedge clk);
    check("rerun_result", 32'(result), 32'h354a);

    // Asynchronous reset while in ISSUE of entry 1.
    mon_on = 1'b0;
    start_run(5'd9, 1'b1);
    repeat (2) @(negedge clk);
    check("ar_in_issue", 32'(dbg_state), 32'(S_ISSUE));
    check("ar_apply_hi", 32'(apply),     32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_apply",    32'(apply),     32'd0);
    check("ar_acc_rst",  32'(acc_rst),   32'd0);
    check("ar_busy",     32'(busy),      32'd0);
    check("ar_alu_op",   32'(alu_op),    32'd0);
    check("ar_sw_out",   32'(sw_out),    32'd0);
    check("ar_result",   32'(result),    32'd0);
    check("ar_step_cnt", 32'(step_cnt),  32'd0);
    check("ar_state",    32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Program contents survive the reset.
    load_exp(9);
    mon_on = 1'b1;
    start_run(5'd9, 1'b1);
    wait_done(100, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd38);
    repeat (2) @(negedge clk);
    check("post_rst_step_cnt", 32'(step_cnt), 32'd9);
    check("post_rst_result",   32'(result),   32'h0001);
    check("post_rst_exp_left", 32'(exp_q.size()), 32'd0);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
